// File: rtl/fourone_arb_pkg.sv
// Shared types and constants for the 4:1 mux round-robin arbiter.
package fourone_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Pointer value that makes requester 0 the first candidate after reset.
  localparam logic [SELW-1:0] LAST_RST = 2'd3;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', wrapping 3 -> 0.
module rr_pick4
  import fourone_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] win,
  output logic            any
);

  logic [SELW-1:0] cand;

  // Walk the search order backwards so the earliest candidate is written last.
  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    win  = last;
    cand = last;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + SELW'(k);
      if (req[cand]) win = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/fourone_mux_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux; grant held until released.
// Optional hold-time bound compiled in with `define FOURONE_ARB_TIMEOUT_EN.
module fourone_mux_arbiter
  import fourone_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 1..255");
  end

  arb_state_e      state_q, state_d;
  logic [SELW-1:0] sel_q,   sel_d;
  logic [SELW-1:0] last_q,  last_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic            busy_q,  busy_d;
  logic            timeout_q, timeout_d;

  logic [SELW-1:0] pick_win;
  logic            pick_any;
  logic            release_norm;
  logic            release_force;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  assign release_norm = done | ~req[sel_q];

`ifdef FOURONE_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed GRANT cycles; the HOLD_MAX-th cycle forces release.
  assign release_force = ({1'b0, cnt_q} + 9'd1) >= 9'(HOLD_MAX);
`else
  assign release_force = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
`ifdef FOURONE_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_win;
          last_d  = pick_win;
          gnt_d   = idx_to_onehot(pick_win);
          busy_d  = 1'b1;
`ifdef FOURONE_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef FOURONE_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // A normal release wins over a forced one, so no timeout pulse then.
        if (release_norm || release_force) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = ~release_norm;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers
  // see the same pre-edge values; reset is synchronous and overrides all else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= LAST_RST;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef FOURONE_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef FOURONE_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

`ifdef FOURONE_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // The pulse register is never set without the bound; keep the pin constant.
  assign timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_fourone_mux_arbiter.sv
// Directed self-checking bench for fourone_mux_arbiter with hand-computed expectations.
module tb_fourone_mux_arbiter;

`ifdef FOURONE_ARB_TIMEOUT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  fourone_mux_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later; also check the grant invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
    if (busy) check("gnt_matches_sel", {4'd0, gnt}, {4'd0, 4'b0001 << sel});
  endtask

  task automatic expect_out(input string tag, input logic [1:0] e_sel, input logic [3:0] e_gnt,
                            input logic e_busy, input logic e_to);
    check({tag, ".sel"},     {6'd0, sel},     {6'd0, e_sel});
    check({tag, ".gnt"},     {4'd0, gnt},     {4'd0, e_gnt});
    check({tag, ".busy"},    {7'd0, busy},    {7'd0, e_busy});
    check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
  endtask

  initial begin
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    rst = 1'b0;
    expect_out("reset", 2'd0, 4'b0000, 1'b0, 1'b0);

    // All four requesting: strict rotation 0,1,2,3,0, done after two grant cycles.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("rr%0d.grant", i), order[i], 4'b0001 << order[i], 1'b1, 1'b0);
      tick();
      expect_out($sformatf("rr%0d.hold", i), order[i], 4'b0001 << order[i], 1'b1, 1'b0);
      done = 1'b1;
      tick();
      expect_out($sformatf("rr%0d.idle", i), order[i], 4'b0000, 1'b0, 1'b0);
      done = 1'b0;
      if (i == 4) req = 4'b0000;
    end
    tick();
    expect_out("quiet", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Lone requester 3, then request drop releases; sel stays at 3.
    req = 4'b1000;
    tick();
    expect_out("req3.grant", 2'd3, 4'b1000, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("req3.drop", 2'd3, 4'b0000, 1'b0, 1'b0);

    // Owner 1 keeps the grant while requester 2 waits.
    req = 4'b0010;
    tick();
    expect_out("own1.grant", 2'd1, 4'b0010, 1'b1, 1'b0);
    req = 4'b0110;
    tick();
    expect_out("own1.ignore2a", 2'd1, 4'b0010, 1'b1, 1'b0);
    tick();
    expect_out("own1.ignore2b", 2'd1, 4'b0010, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("own1.release", 2'd1, 4'b0000, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("own2.grant", 2'd2, 4'b0100, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("own2.drop", 2'd2, 4'b0000, 1'b0, 1'b0);

    // Reset during a grant to owner 2.
    req = 4'b0100;
    tick();
    expect_out("rst.pre", 2'd2, 4'b0100, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b0101;
    tick();
    rst = 1'b0;
    expect_out("rst.mid", 2'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    expect_out("rst.after", 2'd0, 4'b0001, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("rst.drop", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Owner 0 never releases while requester 1 is also pending (last is 0 here,
    // so first set the pointer to 3 with a brief grant of requester 3).
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    expect_out("hold.setup", 2'd3, 4'b0000, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("hold.grant", 2'd0, 4'b0001, 1'b1, 1'b0);
`ifdef FOURONE_ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      expect_out($sformatf("to.hold%0d", c), 2'd0, 4'b0001, 1'b1, 1'b0);
    end
    tick();
    expect_out("to.pulse", 2'd0, 4'b0000, 1'b0, 1'b1);
    tick();
    expect_out("to.next", 2'd1, 4'b0010, 1'b1, 1'b0);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      check($sformatf("hold%0d.gnt", c), {4'd0, gnt}, 8'h01);
      check($sformatf("hold%0d.timeout", c), {7'd0, timeout}, 8'h00);
    end
`endif
    req = 4'b0000;
    tick();
    check("end.busy", {7'd0, busy}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
